usb_pulpino_word_link: RTL and testbench
========================================

# usb_pulpino_word_link

Word-to-byte bridge between the 32-bit USB register side and the 8-bit GPIO byte channel of PULPino. It serializes a USB word into bytes over a toggle ("flicker") handshake toward PULPino. It also assembles bytes arriving from PULPino back into a word for the USB side. It sits directly upstream of the GPIO channel and feeds the usb_to_pulpino data/flicker lines. It consumes the pulpino_to_usb data/flicker lines.

## Interface
Parameters:
- BYTES_PER_WORD, 4: bytes per word, 1..4; WORD_W = 8*BYTES_PER_WORD.
- SYNC_STAGES, 2: synchronizer flops on each incoming flicker line, >=1.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tx_word_i  in  WORD_W  word to send to PULPino.
- tx_valid_i  in  1  tx_word_i valid.
- tx_ready_o  out  1  word accepted when valid&ready at a rising edge.
- byte_o  out  8  byte presented to PULPino.
- write_flicker_o  out  1  toggles once per new byte on byte_o.
- read_flicker_i  in  1  PULPino toggles after consuming byte_o.
- byte_i  in  8  byte presented by PULPino.
- write_flicker_i  in  1  PULPino toggles once per new byte on byte_i.
- read_flicker_o  out  1  toggles after byte_i is captured.
- rx_word_o  out  WORD_W  assembled word.
- rx_valid_o  out  1  rx_word_o valid; held until accepted.
- rx_ready_i  in  1  consumer accepts rx_word_o.

## Operation
- Flicker protocol is level-compared, not edge-detected, so no event is lost:
  - TX byte is outstanding while sync(read_flicker_i) != write_flicker_o.
  - RX byte is pending while sync(write_flicker_i) != read_flicker_o.
- Each sync() is a SYNC_STAGES flop chain, reset to 0. byte_i is not synchronized: the sender holds it stable until acknowledged.
- TX FSM:
  - IDLE: tx_ready_o=1. On accept, load the shift register with tx_word_i. byte_o <= tx_word_i[7:0], write_flicker_o toggles, idx <= 0, go to WAIT_ACK.
  - WAIT_ACK: tx_ready_o=0. When sync(read_flicker_i) == write_flicker_o: if idx == BYTES_PER_WORD-1, go to IDLE. Otherwise shift right 8, byte_o <= next byte, toggle write_flicker_o, idx++.
  - Bytes are sent LSB first. byte_o keeps its last value in IDLE.
- RX FSM:
  - COLLECT: when a byte is pending and rx_valid_o=0, shift byte_i into the word LSB-first (word <= {byte_i, word[WORD_W-1:8]}), toggle read_flicker_o, idx++.
  - On the capture of byte BYTES_PER_WORD-1, the same edge loads rx_word_o and sets rx_valid_o; idx wraps to 0.
  - FULL (rx_valid_o=1): pending bytes are not captured and read_flicker_o is not toggled; back-pressure reaches PULPino.
  - rx_valid_o & rx_ready_i clears rx_valid_o at that edge. Capture of a pending byte resumes on the following edge, never the same one.
- rx_word_o is stable while rx_valid_o=1.
- TX and RX paths are independent and may run concurrently.

## Timing
- Reset values: tx_ready_o=1, byte_o=0, write_flicker_o=0, read_flicker_o=0, rx_word_o=0, rx_valid_o=0, idx=0, TX=IDLE, RX=COLLECT, sync flops=0.
- Reset mid-operation discards any partial word immediately. The PULPino side must be reset together with this block so flicker levels restart at 0.
- An input flicker toggling before edge k is visible to the FSM at edge k+SYNC_STAGES.
- With a zero-delay ack loopback (read_flicker_i = write_flicker_o), each byte takes SYNC_STAGES+1 cycles.
- Word accepted at edge 0 → tx_ready_o returns high after edge BYTES_PER_WORD*(SYNC_STAGES+1); that is edge 12 for the defaults.
- byte_o and write_flicker_o change on the same edge. byte_o is stable for at least one cycle before any ack can be seen.
- tx_valid_i deasserted while tx_ready_o=0 has no effect.

## Test plan
- Reset: hold rst_n=0 with random inputs → tx_ready_o=1, rx_valid_o=0, byte_o/flickers/rx_word_o=0. After release, nothing changes while inputs are idle.
- TX loopback, defaults: send 0xDEADBEEF at edge 0 → byte_o sequence EF, BE, AD, DE; 4 write_flicker_o toggles spaced 3 cycles apart; tx_ready_o=1 after edge 12.
- RX word: PULPino model sends 0x11, 0x22, 0x33, 0x44, each waiting for a read_flicker_o toggle → rx_word_o=0x44332211 with rx_valid_o=1. It stays held through 10 cycles with rx_ready_i=0, then clears the edge after rx_ready_i=1.
- RX back-pressure: rx_valid_o=1 while a 5th byte 0x55 is pending → no read_flicker_o toggle until the handshake. 0x55 is captured exactly one edge after rx_valid_o clears.
- Slow ack: read_flicker_i held for 20 cycles after byte 0 of 0xA5A5_0F0F → byte_o=0x0F stable, no extra toggles, tx_ready_o=0 throughout.
- Reset mid-TX after 2 bytes of 0x01020304, then send 0xCAFEF00D → all outputs go to reset values immediately. The new transfer starts with byte 0x0D, and write_flicker_o is 1 after the first toggle.

Source files
------------

// File: rtl/usb_pulpino_word_link.sv
// Word-to-byte bridge between the 32-bit USB register side and PULPino's 8-bit GPIO byte channel.
// Each direction uses a toggle ("flicker") handshake that compares levels, so a slow peer never loses an event.
module usb_pulpino_word_link #(
  parameter int BYTES_PER_WORD = 4,
  parameter int SYNC_STAGES    = 2,
  localparam int WORD_W        = 8 * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] tx_word_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [7:0]        byte_o,
  output logic              write_flicker_o,
  input  logic              read_flicker_i,
  input  logic [7:0]        byte_i,
  input  logic              write_flicker_i,
  output logic              read_flicker_o,
  output logic [WORD_W-1:0] rx_word_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  typedef enum logic {TX_IDLE, TX_WAIT_ACK} tx_state_e;
  typedef enum logic {RX_COLLECT, RX_FULL}  rx_state_e;

  tx_state_e              tx_state_q, tx_state_d;
  logic [WORD_W-1:0]      tx_shift_q, tx_shift_d;
  logic [7:0]             byte_q, byte_d;
  logic                   wr_flk_q, wr_flk_d;
  logic [IDX_W-1:0]       tx_idx_q, tx_idx_d;

  rx_state_e              rx_state_q, rx_state_d;
  logic [WORD_W-1:0]      rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0]      rx_word_q, rx_word_d;
  logic                   rd_flk_q, rd_flk_d;
  logic [IDX_W-1:0]       rx_idx_q, rx_idx_d;

  logic [SYNC_STAGES-1:0] rd_sync_q, rd_sync_d;
  logic [SYNC_STAGES-1:0] wr_sync_q, wr_sync_d;
  logic                   tx_acked;
  logic                   rx_pending;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      byte_q     <= '0;
      wr_flk_q   <= 1'b0;
      tx_idx_q   <= '0;
      rx_state_q <= RX_COLLECT;
      rx_shift_q <= '0;
      rx_word_q  <= '0;
      rd_flk_q   <= 1'b0;
      rx_idx_q   <= '0;
      rd_sync_q  <= '0;
      wr_sync_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      byte_q     <= byte_d;
      wr_flk_q   <= wr_flk_d;
      tx_idx_q   <= tx_idx_d;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_word_q  <= rx_word_d;
      rd_flk_q   <= rd_flk_d;
      rx_idx_q   <= rx_idx_d;
      rd_sync_q  <= rd_sync_d;
      wr_sync_q  <= wr_sync_d;
    end
  end

  // Synchronizer chains: bit 0 samples the pin, the top bit feeds the FSMs.
  always_comb begin
    rd_sync_d  = SYNC_STAGES'({rd_sync_q, read_flicker_i});
    wr_sync_d  = SYNC_STAGES'({wr_sync_q, write_flicker_i});
    tx_acked   = (rd_sync_q[SYNC_STAGES-1] == wr_flk_q);
    rx_pending = (wr_sync_q[SYNC_STAGES-1] != rd_flk_q);
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    byte_d     = byte_q;
    wr_flk_d   = wr_flk_q;
    tx_idx_d   = tx_idx_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid_i) begin
          tx_shift_d = tx_word_i;
          byte_d     = tx_word_i[7:0];
          wr_flk_d   = ~wr_flk_q;
          tx_idx_d   = '0;
          tx_state_d = TX_WAIT_ACK;
        end
      end
      TX_WAIT_ACK: begin
        if (tx_acked) begin
          if (tx_idx_q == LAST_IDX) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_shift_d = tx_shift_q >> 8;
            byte_d     = tx_shift_d[7:0];
            wr_flk_d   = ~wr_flk_q;
            tx_idx_d   = tx_idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  // A full word blocks capture, so a pending byte stalls PULPino until the consumer drains rx_word_o.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_word_d  = rx_word_q;
    rd_flk_d   = rd_flk_q;
    rx_idx_d   = rx_idx_q;
    unique case (rx_state_q)
      RX_COLLECT: begin
        if (rx_pending) begin
          rx_shift_d = WORD_W'({byte_i, rx_shift_q} >> 8);
          rd_flk_d   = ~rd_flk_q;
          if (rx_idx_q == LAST_IDX) begin
            rx_idx_d   = '0;
            rx_word_d  = rx_shift_d;
            rx_state_d = RX_FULL;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_FULL: begin
        if (rx_ready_i) rx_state_d = RX_COLLECT;
      end
    endcase
  end

  always_comb begin
    tx_ready_o = (tx_state_q == TX_IDLE);
    rx_valid_o = (rx_state_q == RX_FULL);
  end

  assign byte_o          = byte_q;
  assign write_flicker_o = wr_flk_q;
  assign read_flicker_o  = rd_flk_q;
  assign rx_word_o       = rx_word_q;

endmodule

// File: tb/tb_usb_pulpino_word_link.sv
// Directed bench for usb_pulpino_word_link: TX loopback/slow-ack, RX assembly/back-pressure, reset.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_usb_pulpino_word_link;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] tx_word_i;
  logic         tx_valid_i;
  logic         tx_ready_o;
  logic [7:0]   byte_o;
  logic         write_flicker_o;
  logic         read_flicker_i;
  logic [7:0]   byte_i;
  logic         write_flicker_i;
  logic         read_flicker_o;
  logic [W-1:0] rx_word_o;
  logic         rx_valid_o;
  logic         rx_ready_i;

  logic loopback;
  logic rd_fl_manual;
  logic exp_wf;
  logic exp_rf;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } tx_vec_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] word;
  } rx_vec_t;

  tx_vec_t tx_tab[4];
  rx_vec_t rx_tab[3];

  assign read_flicker_i = loopback ? write_flicker_o : rd_fl_manual;

  always #5 clk = ~clk;

  usb_pulpino_word_link #(.BYTES_PER_WORD(4), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tx_word_i       (tx_word_i),
    .tx_valid_i      (tx_valid_i),
    .tx_ready_o      (tx_ready_o),
    .byte_o          (byte_o),
    .write_flicker_o (write_flicker_o),
    .read_flicker_i  (read_flicker_i),
    .byte_i          (byte_i),
    .write_flicker_i (write_flicker_i),
    .read_flicker_o  (read_flicker_o),
    .rx_word_o       (rx_word_o),
    .rx_valid_o      (rx_valid_o),
    .rx_ready_i      (rx_ready_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_ready"}, 32'(tx_ready_o), 32'd1);
    check({tag, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
    check({tag, "_byte_o"}, 32'(byte_o), 32'd0);
    check({tag, "_wr_flk"}, 32'(write_flicker_o), 32'd0);
    check({tag, "_rd_flk"}, 32'(read_flicker_o), 32'd0);
    check({tag, "_rx_word"}, rx_word_o, 32'd0);
  endtask

  // Loopback TX of one word: toggles expected after edges 0,3,6,9; idle again after edge 12.
  // tx_valid_i stays high with junk data while busy to show it is ignored.
  task automatic run_tx(input tx_vec_t v);
    logic [7:0] eb[4];
    int bi;
    eb[0] = v.b0; eb[1] = v.b1; eb[2] = v.b2; eb[3] = v.b3;
    check("tx_ready_before", 32'(tx_ready_o), 32'd1);
    tx_word_i  = v.word;
    tx_valid_i = 1'b1;
    @(negedge clk);
    exp_wf = ~exp_wf;
    check("tx_byte_e0", 32'(byte_o), 32'(eb[0]));
    check("tx_wflk_e0", 32'(write_flicker_o), 32'(exp_wf));
    check("tx_busy_e0", 32'(tx_ready_o), 32'd0);
    for (int c = 1; c <= 12; c++) begin
      tx_word_i  = $urandom;
      tx_valid_i = 1'b1;
      @(negedge clk);
      if (c % 3 == 0 && c < 12) exp_wf = ~exp_wf;
      bi = (c / 3 > 3) ? 3 : c / 3;
      check($sformatf("tx_byte_e%0d", c), 32'(byte_o), 32'(eb[bi]));
      check($sformatf("tx_wflk_e%0d", c), 32'(write_flicker_o), 32'(exp_wf));
      check($sformatf("tx_ready_e%0d", c), 32'(tx_ready_o), (c == 12) ? 32'd1 : 32'd0);
    end
    tx_valid_i = 1'b0;
  endtask

  // PULPino sender: present a byte, toggle its flicker, optionally wait for the capture ack.
  task automatic send_rx_byte(input logic [7:0] b, input bit wait_ack);
    int k;
    @(negedge clk);
    byte_i          = b;
    write_flicker_i = ~write_flicker_i;
    if (wait_ack) begin
      k = 0;
      while (read_flicker_o === exp_rf && k < 20) begin
        @(negedge clk);
        k++;
      end
      exp_rf = ~exp_rf;
      check("rx_ack", 32'(read_flicker_o), 32'(exp_rf));
    end
  endtask

  task automatic consume_rx();
    rx_ready_i = 1'b1;
    @(negedge clk);
    check("rx_cleared", 32'(rx_valid_o), 32'd0);
    rx_ready_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tx_tab[0] = '{32'hDEADBEEF, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    tx_tab[1] = '{32'h00000000, 8'h00, 8'h00, 8'h00, 8'h00};
    tx_tab[2] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tx_tab[3] = '{32'h01020304, 8'h04, 8'h03, 8'h02, 8'h01};
    rx_tab[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
    rx_tab[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 32'hFF00FF00};
    rx_tab[2] = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 32'h3CC35AA5};

    // Reset with busy-looking inputs.
    rst_n           = 1'b0;
    loopback        = 1'b0;
    tx_word_i       = $urandom;
    tx_valid_i      = 1'b1;
    byte_i          = 8'($urandom);
    write_flicker_i = 1'b1;
    rd_fl_manual    = 1'b1;
    rx_ready_i      = 1'b1;
    exp_wf          = 1'b0;
    exp_rf          = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_held");

    tx_valid_i      = 1'b0;
    write_flicker_i = 1'b0;
    rd_fl_manual    = 1'b0;
    rx_ready_i      = 1'b0;
    rst_n           = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("rst_idle");

    // TX table through a zero-delay ack loopback.
    loopback = 1'b1;
    foreach (tx_tab[i]) run_tx(tx_tab[i]);

    // RX table; the first word is also held for 10 cycles without rx_ready_i.
    foreach (rx_tab[i]) begin
      send_rx_byte(rx_tab[i].b0, 1'b1);
      send_rx_byte(rx_tab[i].b1, 1'b1);
      send_rx_byte(rx_tab[i].b2, 1'b1);
      check("rx_not_yet_valid", 32'(rx_valid_o), 32'd0);
      send_rx_byte(rx_tab[i].b3, 1'b1);
      check("rx_valid", 32'(rx_valid_o), 32'd1);
      check("rx_word", rx_word_o, rx_tab[i].word);
      if (i == 0) begin
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("rx_hold_valid", 32'(rx_valid_o), 32'd1);
          check("rx_hold_word", rx_word_o, rx_tab[i].word);
        end
      end
      consume_rx();
    end

    // Back-pressure: a 5th byte arrives while the word is still unread.
    send_rx_byte(8'h11, 1'b1);
    send_rx_byte(8'h22, 1'b1);
    send_rx_byte(8'h33, 1'b1);
    send_rx_byte(8'h44, 1'b1);
    check("bp_word", rx_word_o, 32'h44332211);
    send_rx_byte(8'h55, 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check("bp_no_ack", 32'(read_flicker_o), 32'(exp_rf));
      check("bp_valid", 32'(rx_valid_o), 32'd1);
    end
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
    check("bp_cleared", 32'(rx_valid_o), 32'd0);
    check("bp_no_same_edge_ack", 32'(read_flicker_o), 32'(exp_rf));
    @(negedge clk);
    exp_rf = ~exp_rf;
    check("bp_ack_next_edge", 32'(read_flicker_o), 32'(exp_rf));
    send_rx_byte(8'h66, 1'b1);
    send_rx_byte(8'h77, 1'b1);
    send_rx_byte(8'h88, 1'b1);
    check("bp_word2_valid", 32'(rx_valid_o), 32'd1);
    check("bp_word2", rx_word_o, 32'h88776655);
    consume_rx();

    // Slow ack: PULPino sits on byte 0 for 20 cycles.
    loopback     = 1'b0;
    rd_fl_manual = exp_wf;
    @(negedge clk);
    tx_word_i  = 32'hA5A50F0F;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    exp_wf     = ~exp_wf;
    for (int c = 0; c < 20; c++) begin
      check("slow_byte", 32'(byte_o), 32'h0F);
      check("slow_wflk", 32'(write_flicker_o), 32'(exp_wf));
      check("slow_busy", 32'(tx_ready_o), 32'd0);
      @(negedge clk);
    end
    loopback = 1'b1;
    k = 0;
    while (tx_ready_o !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    exp_wf = exp_wf ^ 1'b1;
    check("slow_done", 32'(tx_ready_o), 32'd1);
    check("slow_last_byte", 32'(byte_o), 32'hA5);
    check("slow_end_wflk", 32'(write_flicker_o), 32'(exp_wf));

    // Reset in the middle of a transfer, then a clean new word.
    @(negedge clk);
    tx_word_i  = 32'h01020304;
    tx_valid_i = 1'b1;
    @(negedge clk);
    tx_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    check("midtx_byte_before", 32'(byte_o), 32'h03);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midtx_rst");
    write_flicker_i = 1'b0;
    exp_wf          = 1'b0;
    exp_rf          = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midtx_release");
    run_tx('{32'hCAFEF00D, 8'h0D, 8'hF0, 8'hFE, 8'hCA});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
